// File: rtl/ray_batch_sequencer.sv
// Ray batch sequencer: fetches a ray's primitive batches, feeds the closest-hit tester, reduces results.
// Optional early exit for any-hit (shadow) rays is enabled with RAYSEQ_EARLY_EXIT_EN.

package ray_seq_pkg;

    localparam int AABB_TEST_UNIT_SIZE = 4;

    typedef logic signed [31:0] Fixed;

    localparam Fixed FIXED_INF = 32'sh7FFF_FFFF;

    function automatic Fixed FixedInf();
        return FIXED_INF;
    endfunction

    typedef struct packed {
        Fixed org_x;
        Fixed org_y;
        Fixed org_z;
        Fixed dir_x;
        Fixed dir_y;
        Fixed dir_z;
    } Ray;

    typedef struct packed {
        Fixed min_x;
        Fixed min_y;
        Fixed min_z;
        Fixed max_x;
        Fixed max_y;
        Fixed max_z;
    } Primitive_AABB;

    typedef struct packed {
        logic        bHit;
        Fixed        T;
        logic [15:0] PI;
    } HitData;

    localparam HitData HIT_NONE = '{bHit: 1'b0, T: FIXED_INF, PI: 16'h0000};

endpackage

module ray_batch_sequencer
    import ray_seq_pkg::*;
#(
    parameter int BATCH_WIDTH = AABB_TEST_UNIT_SIZE,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  Ray                    in_ray,
    input  logic [ADDR_WIDTH-1:0] in_base,
    input  logic [ADDR_WIDTH:0]   in_count,
    input  logic                  in_any_hit,

    output logic                  prim_rd_en,
    output logic [ADDR_WIDTH-1:0] prim_addr,
    input  Primitive_AABB         prim_rd_data [BATCH_WIDTH],

    output Ray                    test_ray,
    output Primitive_AABB         test_aabb [BATCH_WIDTH],
    input  HitData                test_hit,

    output logic                  out_valid,
    input  logic                  out_ready,
    output HitData                out_hit,
    output logic                  busy
);

    // state  | meaning
    // IDLE   | waiting for a ray, in_ready high
    // FETCH  | memory read strobe for batch idx
    // LOAD   | read data captured into test_aabb
    // TEST   | tester result merged into accumulator
    // DONE   | result held until out_ready
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_TEST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    Ray                      ray_q, ray_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [ADDR_WIDTH:0]     idx_q, idx_d;
    HitData                  acc_q, acc_d;
    Primitive_AABB           aabb_q [BATCH_WIDTH];
    Primitive_AABB           aabb_d [BATCH_WIDTH];

    logic                    take_hit;
    logic                    last_batch;
    logic                    early_exit;

`ifdef RAYSEQ_EARLY_EXIT_EN
    logic any_hit_q, any_hit_d;

    assign early_exit = any_hit_q && test_hit.bHit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            any_hit_q <= 1'b0;
        end else begin
            any_hit_q <= any_hit_d;
        end
    end

    always_comb begin
        any_hit_d = any_hit_q;
        if ((state_q == S_IDLE) && in_valid) begin
            any_hit_d = in_any_hit;
        end
    end
`else
    logic unused_in_any_hit;

    assign unused_in_any_hit = in_any_hit;
    assign early_exit        = 1'b0;
`endif

    // Strict compare keeps the earlier batch on equal T.
    assign take_hit   = test_hit.bHit && ($signed(test_hit.T) < $signed(acc_q.T));
    assign last_batch = (idx_q == (count_q - CNT_ONE));

    always_comb begin
        state_d = state_q;
        ray_d   = ray_q;
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        aabb_d  = aabb_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ray_d   = in_ray;
                    base_d  = in_base;
                    count_d = in_count;
                    idx_d   = '0;
                    acc_d   = HIT_NONE;
                    state_d = (in_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                aabb_d  = prim_rd_data;
                state_d = S_TEST;
            end
            S_TEST: begin
                if (take_hit) begin
                    acc_d = test_hit;
                end
                if (last_batch || early_exit) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + CNT_ONE;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ray_q   <= '0;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            acc_q   <= HIT_NONE;
            for (int i = 0; i < BATCH_WIDTH; i++) begin
                aabb_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ray_q   <= ray_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            aabb_q  <= aabb_d;
        end
    end

    // Address wraps naturally at 2^ADDR_WIDTH.
    assign prim_addr  = base_q + idx_q[ADDR_WIDTH-1:0];
    assign prim_rd_en = (state_q == S_FETCH);
    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_hit    = acc_q;
    assign test_ray   = ray_q;
    assign test_aabb  = aabb_q;

endmodule

// File: tb/tb_ray_batch_sequencer.sv
// Scoreboard bench for ray_batch_sequencer: memory and tester models, queue-based reference checking.
module tb_ray_batch_sequencer;
    import ray_seq_pkg::*;

    localparam int BW = AABB_TEST_UNIT_SIZE;
    localparam int AW = 8;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    Ray            in_ray;
    logic [AW-1:0] in_base;
    logic [AW:0]   in_count;
    logic          in_any_hit;
    logic          prim_rd_en;
    logic [AW-1:0] prim_addr;
    Primitive_AABB rd_data [BW];
    Ray            test_ray;
    Primitive_AABB test_aabb [BW];
    HitData        test_hit;
    logic          out_valid;
    logic          out_ready;
    HitData        out_hit;
    logic          busy;

    ray_batch_sequencer #(.BATCH_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_ray(in_ray),
        .in_base(in_base), .in_count(in_count), .in_any_hit(in_any_hit),
        .prim_rd_en(prim_rd_en), .prim_addr(prim_addr), .prim_rd_data(rd_data),
        .test_ray(test_ray), .test_aabb(test_aabb), .test_hit(test_hit),
        .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit), .busy(busy)
    );

    typedef struct {
        HitData hit;
        int     lat;
        int     reads;
    } exp_t;

    exp_t          exp_q[$];
    int            addr_q[$];
    Primitive_AABB mem [256][BW];

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     accept_cyc = 0;
    int     rd_cnt = 0;
    bit     seen = 0;
    bit     active = 0;
    HitData held;
    Ray     cur_ray;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous primitive memory: data valid one cycle after the read strobe.
    always @(posedge clk) begin
        if (prim_rd_en) begin
            for (int l = 0; l < BW; l++) rd_data[l] <= mem[prim_addr][l];
        end
    end

    // Stand-in closest-hit tester: lane hits when max_x != 0, T in min_x, PI in min_y.
    always_comb begin
        test_hit = HIT_NONE;
        for (int l = 0; l < BW; l++) begin
            if ((test_aabb[l].max_x != 0) &&
                (!test_hit.bHit || ($signed(test_aabb[l].min_x) < $signed(test_hit.T)))) begin
                test_hit.bHit = 1'b1;
                test_hit.T    = test_aabb[l].min_x;
                test_hit.PI   = test_aabb[l].min_y[15:0];
            end
        end
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 256; a++)
            for (int l = 0; l < BW; l++) mem[a][l] = '0;
    endtask

    task automatic set_lane(input int a, input int l, input int t, input int pi);
        mem[a][l]       = '0;
        mem[a][l].max_x = 32'sd1;
        mem[a][l].min_x = t;
        mem[a][l].min_y = pi & 32'hFFFF;
    endtask

    task automatic random_mem();
        int t;
        for (int a = 0; a < 256; a++)
            for (int l = 0; l < BW; l++) begin
                mem[a][l] = '0;
                if ($urandom_range(0, 2) == 0) begin
                    t = ($urandom_range(0, 40) - 20) * 16384;
                    set_lane(a, l, t, $urandom_range(0, 65535));
                end
            end
    endtask

    // Reference: first-occurring minimum T over the flattened primitive list.
    task automatic predict(input int base, input int count, input bit any);
        exp_t e;
        bit   batch_hit;
        int   a;
        e.hit   = HIT_NONE;
        e.reads = 0;
        for (int b = 0; b < count; b++) begin
            a = (base + b) % 256;
            addr_q.push_back(a);
            e.reads++;
            batch_hit = 0;
            for (int l = 0; l < BW; l++) begin
                if (mem[a][l].max_x != 0) begin
                    batch_hit = 1;
                    if ($signed(mem[a][l].min_x) < $signed(e.hit.T)) begin
                        e.hit.bHit = 1'b1;
                        e.hit.T    = mem[a][l].min_x;
                        e.hit.PI   = mem[a][l].min_y[15:0];
                    end
                end
            end
`ifdef RAYSEQ_EARLY_EXIT_EN
            if (any && batch_hit) break;
`endif
        end
        e.lat = (count == 0) ? 1 : 3 * e.reads + 1;
        exp_q.push_back(e);
    endtask

    function automatic Ray rand_ray();
        Ray r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (resetn) begin
            if (prim_rd_en) begin
                rd_cnt++;
                if (addr_q.size() == 0) begin
                    chk("extra_read", 1, 0);
                end else begin
                    a = addr_q.pop_front();
                    chk("prim_addr", prim_addr, a);
                end
            end
            if (active && busy && !out_valid) chk("test_ray_stable", test_ray, cur_ray);
            if (out_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_bHit", out_hit.bHit, e.hit.bHit);
                        chk("out_T", out_hit.T, e.hit.T);
                        chk("out_PI", out_hit.PI, e.hit.PI);
                        chk("latency", cyc - accept_cyc + 1, e.lat);
                        chk("read_count", rd_cnt, e.reads);
                    end
                    held = out_hit;
                    seen = 1;
                end else begin
                    chk("out_hit_hold", out_hit, held);
                end
                chk("in_ready_in_done", in_ready, 0);
                if (out_ready) seen = 0;
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_prim_rd_en", prim_rd_en, 0);
        chk("rst_prim_addr", prim_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_bHit", out_hit.bHit, 0);
        chk("rst_out_T", out_hit.T, FIXED_INF);
        for (int l = 0; l < BW; l++) chk("rst_test_aabb", test_aabb[l], 0);
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = in_ready;
        if (!ok) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic issue(input int base, input int count, input bit any);
        cur_ray    = rand_ray();
        in_ray     = cur_ray;
        in_base    = base[AW-1:0];
        in_count   = count[AW:0];
        in_any_hit = any;
        in_valid   = 1'b1;
        predict(base, count, any);
        @(posedge clk); #1;
        accept_cyc = cyc;
        rd_cnt     = 0;
        active     = 1;
        in_valid   = 1'b0;
        in_ray     = rand_ray();
        in_base    = $urandom_range(0, 255);
        in_count   = $urandom_range(0, 511);
        in_any_hit = $urandom_range(0, 1);
    endtask

    task automatic run_ray(input int base, input int count, input bit any, input int hold);
        bit ok;
        int n;
        wait_ready(ok);
        if (!ok) return;
        issue(base, count, any);
        n = 0;
        while (!out_valid && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
            exp_q.delete();
            addr_q.delete();
            active = 0;
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        active    = 0;
    endtask

    initial begin
        bit ok;
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ray = '0; in_base = '0; in_count = '0; in_any_hit = 1'b0;
        for (int l = 0; l < BW; l++) rd_data[l] = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        run_ray(5, 0, 0, 2);

        clear_mem();
        set_lane(10, 2, 5 << 16, 16'h0111);
        set_lane(11, 0, 2 << 16, 16'h0222);
        set_lane(12, 3, 7 << 16, 16'h0333);
        run_ray(10, 3, 0, 0);

        clear_mem();
        set_lane(20, 1, 3 << 16, 16'h00A0);
        set_lane(21, 0, 3 << 16, 16'h00B0);
        run_ray(20, 2, 0, 1);

        clear_mem();
        run_ray(30, 4, 0, 0);

        set_lane(254, 0, 9 << 16, 16'h0254);
        set_lane(255, 1, 4 << 16, 16'h0255);
        set_lane(0, 2, -(1 << 16), 16'h0300);
        run_ray(254, 3, 0, 20);

        clear_mem();
        set_lane(41, 2, 6 << 16, 16'h0041);
        set_lane(43, 0, 1 << 16, 16'h0043);
        run_ray(40, 4, 1, 0);

        // Reset pulsed during the second batch's LOAD cycle.
        clear_mem();
        set_lane(50, 0, 8 << 16, 16'h0050);
        set_lane(51, 0, 2 << 16, 16'h0051);
        wait_ready(ok);
        if (ok) begin
            issue(50, 2, 0);
            repeat (4) begin
                @(posedge clk); #1;
            end
            chk("abort_in_load_busy", busy, 1);
            chk("abort_in_load_rd_en", prim_rd_en, 0);
            resetn = 1'b0;
            #1;
            exp_q.delete();
            addr_q.delete();
            active = 0;
            seen   = 0;
            check_reset_vals();
            @(posedge clk); #1;
            @(negedge clk);
            check_reset_vals();
            @(posedge clk); #1;
            resetn = 1'b1;
            @(posedge clk); #1;
        end
        run_ray(51, 1, 0, 0);

        random_mem();
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 7) random_mem();
            run_ray($urandom_range(0, 255), $urandom_range(0, 6), $urandom_range(0, 1),
                    $urandom_range(0, 3));
        end
        run_ray($urandom_range(0, 255), 256, 0, 1);

        repeat (3) @(posedge clk);
        chk("leftover_expected", exp_q.size(), 0);
        chk("leftover_addresses", addr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ray_batch_sequencer.md
# ray_batch_sequencer

Ray-side sequencer for the primitive hit tester: accepts one ray, streams its primitive list from primitive memory in batches of `AABB_TEST_UNIT_SIZE`, and presents each batch to the combinational closest-hit unit. It folds the per-batch results into a running closest hit and returns one final `HitData` per ray. It sits between the ray generator/shader front end and `RayUnit_FindClosestHit`, and owns the memory reads and the multi-batch reduction that the tester does not perform.

## Interface
- `BATCH_WIDTH`, default `AABB_TEST_UNIT_SIZE`: primitives per memory word and per test.
- `ADDR_WIDTH`, default 8: batch address width.
- `clk` in 1: clock. All state updates on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: ray request valid.
- `in_ready` out 1: high only in IDLE.
- `in_ray` in `Ray`: ray to trace.
- `in_base` in ADDR_WIDTH: first batch address.
- `in_count` in ADDR_WIDTH+1: number of batches, 0 to 2^ADDR_WIDTH.
- `in_any_hit` in 1: shadow-ray request; used only with `RAYSEQ_EARLY_EXIT_EN`.
- `prim_rd_en` out 1: memory read strobe.
- `prim_addr` out ADDR_WIDTH: batch address.
- `prim_rd_data` in `Primitive_AABB[BATCH_WIDTH]`: batch data, valid exactly 1 cycle after `prim_rd_en`.
- `test_ray` out `Ray`: registered ray to the tester.
- `test_aabb` out `Primitive_AABB[BATCH_WIDTH]`: registered batch to the tester.
- `test_hit` in `HitData`: combinational closest hit of the current batch.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result accepted.
- `out_hit` out `HitData`: final closest hit.
- `busy` out 1: state is not IDLE.

## Operation
- **States:** IDLE, FETCH, LOAD, TEST, DONE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid`, latch `in_ray`, `in_base`, `in_count` and `in_any_hit`.
  - Initialise the accumulator to `bHit=0`, `T=FixedInf()`, and clear the batch index.
  - `in_count==0` goes to DONE. Otherwise go to FETCH.
- **FETCH**
  - `prim_rd_en=1` for exactly this cycle.
  - `prim_addr = in_base + index`, computed modulo 2^ADDR_WIDTH, so the address wraps.
  - Next state is LOAD.
- **LOAD**
  - Capture `prim_rd_data` into the `test_aabb` register.
  - Next state is TEST.
- **TEST:** merge `test_hit` into the accumulator.
  - Replace the accumulator when `test_hit.bHit && test_hit.T < acc.T` (signed Fixed compare, strict).
  - On equal T, the earlier batch is kept.
  - If `index == in_count-1`, go to DONE. Otherwise increment the index and go to FETCH.
- **DONE**
  - `out_valid=1` and `out_hit` = accumulator, both held stable until `out_ready`.
  - On `out_ready`, go to IDLE.
  - `in_ready` stays 0 in DONE, so a new ray is accepted no earlier than the cycle after the handshake.
- **Register stability:** `test_ray` is the latched ray and is stable for the whole operation. `in_*` changes after acceptance are ignored.

## Timing
- **Reset values:**
  - State IDLE.
  - `in_ready=1`, `out_valid=0`, `prim_rd_en=0`, `prim_addr=0`, `busy=0`.
  - `out_hit.bHit=0`, `out_hit.T=FixedInf()`.
  - `test_aabb` and the accumulator are cleared.
- **Per-batch cost:** each batch takes 3 cycles (FETCH, LOAD, TEST).
- **Latency:** from the accept edge to `out_valid` high is 3·N+1 cycles for N>0, and 1 cycle for N=0.
- **Tester timing:** `test_hit` is sampled only in TEST, one cycle after `test_aabb` updates. The tester's combinational path must close within one cycle.
- **Reset mid-operation:**
  - Any state returns to IDLE and the accumulator is discarded.
  - No `out_valid` pulse is produced for the aborted ray.
  - An outstanding memory read is ignored.
- **Back-pressure:** `out_ready` may be held low indefinitely; DONE holds its outputs unchanged.

## Configuration
- **Macro:** `RAYSEQ_EARLY_EXIT_EN`.
- **Defined:** in TEST, if the latched `in_any_hit=1` and `test_hit.bHit=1`:
  - merge the hit as usual;
  - go directly to DONE, skipping the remaining batches.
  - Latency is 3·k+1, where k is the index of the first hit batch plus one.
- **Undefined:**
  - The `in_any_hit` port remains but is ignored.
  - Every request scans all `in_count` batches.

## Test plan
- **Empty list:** `in_count=0` → `out_valid` the cycle after accept, with `bHit=0`, `T=FixedInf()`, and `prim_rd_en` never asserted.
- **Multi-batch min:** 3 batches with hit T = 5.0, 2.0, 7.0 → `out_hit.T=2.0` with batch 1's `PI`.
  - `out_valid` asserts 10 cycles after accept.
  - `prim_addr` sequence is base, base+1, base+2.
- **Tie and no-hit:**
  - Batches with T = 3.0 and 3.0 → batch 0's `PI` is returned.
  - All batches miss → `bHit=0`, `T=FixedInf()`.
- **Wrap and back-pressure:**
  - `ADDR_WIDTH=8`, `in_base=254`, `in_count=3` → addresses 254, 255, 0.
  - `out_ready` held low 20 cycles → `out_hit` stable, `in_ready=0`.
- **Reset abort:** `resetn` pulsed low during the second batch's LOAD → all outputs return to reset values. A fresh 1-batch ray afterwards completes correctly in 4 cycles.
- **Early exit:** `RAYSEQ_EARLY_EXIT_EN` defined, `in_any_hit=1`, 4 batches, first hit in batch 1 → `bHit=1` after 7 cycles, with only 2 reads issued. The same stimulus with the macro undefined → 13 cycles and 4 reads.
